game_state_ctrl: RTL and testbench

Top-level game sequencer. It produces the 3-bit `state` bus consumed by the character, map and display blocks, and counts down the round timer. It looks up the map tile under the character's pixel position through a two-stage registered pipeline and decides WIN or LOSE. It sits between the button inputs and every block that decodes INIT/WAIT/GAME/WIN/LOSE.

---
 rtl/game_state_if.sv | 22 ++
 rtl/game_state_ctrl.sv | 127 ++++++++++++
 tb/tb_game_state_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_state_if.sv
// rtl/game_state_if.sv - button, character position and map inputs plus game state outputs
interface game_state_if;
  logic         start;
  logic [8:0]   charactor_h;
  logic [8:0]   charactor_v;
  logic [0:899] map;
  logic [2:0]   state;
  logic [6:0]   time_left;
  logic         game_tick;
  logic [4:0]   tile_h;
  logic [4:0]   tile_v;

  modport master (
    output start, charactor_h, charactor_v, map,
    input  state, time_left, game_tick, tile_h, tile_v
  );

  modport slave (
    input  start, charactor_h, charactor_v, map,
    output state, time_left, game_tick, tile_h, tile_v
  );
endinterface

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - game sequencer: INIT/WAIT/GAME/WIN/LOSE, round timer, tile lookup
module game_state_ctrl #(
  parameter int TICK_CNT   = 100000000,
  parameter int TIME_LIMIT = 60,
  parameter int INIT_HOLD  = 16
) (
  input logic         clk,
  input logic         rst,
  game_state_if.slave gs
);
  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_WAIT = 3'd1,
    S_GAME = 3'd2,
    S_WIN  = 3'd3,
    S_LOSE = 3'd4
  } state_t;

  localparam logic [2:0] TILE_NONE     = 3'd0;
  localparam logic [2:0] TILE_TERMINAL = 3'd2;

  localparam int TW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam int IW = (INIT_HOLD > 1) ? $clog2(INIT_HOLD) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_CNT - 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_HOLD - 1);
  localparam logic [6:0]    TL_INIT   = 7'(TIME_LIMIT);

  state_t        st;
  logic [TW-1:0] tick_cnt;
  logic [IW-1:0] init_cnt;
  logic          start_d;
  logic [6:0]    time_left_q;
  logic          game_tick_q;
  logic [4:0]    tile_h_q;
  logic [4:0]    tile_v_q;
  logic          oob, v1, oob2, v2;
  logic [2:0]    tile_code;

  logic          start_rise;
  logic [8:0]    idx;
  logic [9:0]    bit_idx;
  logic          tick_wrap, timeout, win_hit, lose_hit;

  assign start_rise = gs.start & ~start_d;

  // idx may overflow 9 bits for off-map tiles; those lookups are masked by oob
  assign idx     = {4'd0, tile_h_q} + 9'(tile_v_q) * 9'd20;
  assign bit_idx = 10'(idx) * 10'd3;

  assign tick_wrap = (st == S_GAME) && (tick_cnt == TICK_MAX);
  assign timeout   = tick_wrap && (time_left_q == 7'd1);
  assign win_hit   = v2 && (tile_code == TILE_TERMINAL);
  assign lose_hit  = v2 && (oob2 || (tile_code == TILE_NONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_INIT;
      tick_cnt    <= '0;
      init_cnt    <= '0;
      start_d     <= 1'b0;
      time_left_q <= TL_INIT;
      game_tick_q <= 1'b0;
      tile_h_q    <= 5'd0;
      tile_v_q    <= 5'd0;
      oob         <= 1'b0;
      v1          <= 1'b0;
      oob2        <= 1'b0;
      v2          <= 1'b0;
      tile_code   <= 3'd0;
    end else begin
      start_d     <= gs.start;
      game_tick_q <= 1'b0;
      case (st)
        S_INIT: begin
          time_left_q <= TL_INIT;
          init_cnt    <= init_cnt + IW'(1);
          if (init_cnt == INIT_LAST) st <= S_WAIT;
        end
        S_WAIT: begin
          if (start_rise) begin
            st          <= S_GAME;
            tick_cnt    <= '0;
            time_left_q <= TL_INIT;
            v1          <= 1'b0;
            v2          <= 1'b0;
          end
        end
        S_GAME: begin
          tile_h_q  <= gs.charactor_h[8:4];
          tile_v_q  <= gs.charactor_v[8:4];
          oob       <= (gs.charactor_h >= 9'd320) || (gs.charactor_v >= 9'd240);
          v1        <= 1'b1;
          oob2      <= oob;
          v2        <= v1;
          tile_code <= oob ? 3'd0 : gs.map[bit_idx +: 3];
          if (tick_wrap) begin
            tick_cnt    <= '0;
            time_left_q <= time_left_q - 7'd1;
            game_tick_q <= 1'b1;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
          // a terminal hit outranks both tile loss and timeout on the same edge
          if (win_hit)                  st <= S_WIN;
          else if (lose_hit || timeout) st <= S_LOSE;
        end
        S_WIN, S_LOSE: begin
          if (start_rise) begin
            st          <= S_INIT;
            init_cnt    <= '0;
            time_left_q <= TL_INIT;
          end
        end
        default: begin
          st       <= S_INIT;
          init_cnt <= '0;
        end
      endcase
    end
  end

  assign gs.state     = st;
  assign gs.time_left = time_left_q;
  assign gs.game_tick = game_tick_q;
  assign gs.tile_h    = tile_h_q;
  assign gs.tile_v    = tile_v_q;
endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - scoreboard bench for game_state_ctrl with directed scenarios
module tb_game_state_ctrl;
  localparam int TICK_CNT   = 4;
  localparam int TIME_LIMIT = 3;
  localparam int INIT_HOLD  = 2;

  localparam int F_STATE = 0, F_TL = 1, F_TICK = 2, F_TH = 3, F_TV = 4;
  localparam int ST_INIT = 0, ST_WAIT = 1, ST_GAME = 2, ST_WIN = 3, ST_LOSE = 4;

  typedef struct {
    int    cyc;
    int    fld;
    int    val;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  game_state_if gs();

  game_state_ctrl #(
    .TICK_CNT  (TICK_CNT),
    .TIME_LIMIT(TIME_LIMIT),
    .INIT_HOLD (INIT_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gs (gs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get_fld(input int fld);
    case (fld)
      F_STATE: return int'(gs.state);
      F_TL:    return int'(gs.time_left);
      F_TICK:  return int'(gs.game_tick);
      F_TH:    return int'(gs.tile_h);
      default: return int'(gs.tile_v);
    endcase
  endfunction

  // expectation for the outputs seen dc edges from now
  task automatic expect_at(input int dc, input int fld, input int val, input string name);
    exp_t e;
    e.cyc  = cyc + dc;
    e.fld  = fld;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_tile(input int tx, input int ty, input int code);
    int         b;
    logic [2:0] c;
    b = (tx + 20 * ty) * 3;
    c = 3'(code);
    gs.map[b]     = c[2];
    gs.map[b + 1] = c[1];
    gs.map[b + 2] = c[0];
  endtask

  task automatic begin_game(input int h, input int v);
    gs.start       = 1'b1;
    gs.charactor_h = 9'(h);
    gs.charactor_v = 9'(v);
    expect_at(1, F_STATE, ST_GAME, "game_enter");
    expect_at(1, F_TL, TIME_LIMIT, "game_tl_load");
    wait_cyc(1);
    gs.start = 1'b0;
  endtask

  task automatic restart();
    gs.start = 1'b1;
    expect_at(1, F_STATE, ST_INIT, "restart_init");
    expect_at(2, F_STATE, ST_INIT, "restart_init_hold");
    expect_at(3, F_STATE, ST_WAIT, "restart_wait");
    wait_cyc(1);
    gs.start = 1'b0;
    wait_cyc(2);
  endtask

  always @(negedge clk) begin : monitor
    int i;
    int act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc < cyc) begin
          failures++;
          $display("FAIL %s expired: due cycle %0d, now %0d", sb[i].name, sb[i].cyc, cyc);
        end else begin
          act = get_fld(sb[i].fld);
          if (act != sb[i].val) begin
            failures++;
            $display("FAIL %s cycle %0d: actual=%0d expected=%0d", sb[i].name, cyc, act, sb[i].val);
          end
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    rst            = 1'b1;
    gs.start       = 1'b1;
    gs.charactor_h = 9'd0;
    gs.charactor_v = 9'd0;
    for (int ty = 0; ty < 15; ty++)
      for (int tx = 0; tx < 20; tx++)
        set_tile(tx, ty, 1);
    set_tile(5, 4, 2);
    set_tile(0, 0, 0);

    // reset state, start held high from reset
    expect_at(1, F_STATE, ST_INIT, "rst_state");
    expect_at(1, F_TL, TIME_LIMIT, "rst_time_left");
    expect_at(1, F_TICK, 0, "rst_game_tick");
    expect_at(1, F_TH, 0, "rst_tile_h");
    expect_at(1, F_TV, 0, "rst_tile_v");
    wait_cyc(2);
    rst = 1'b0;
    expect_at(1, F_STATE, ST_INIT, "s1_init");
    expect_at(1, F_TL, TIME_LIMIT, "s1_init_tl");
    expect_at(2, F_STATE, ST_WAIT, "s1_wait");
    expect_at(5, F_STATE, ST_WAIT, "s1_held_start_ignored");
    wait_cyc(5);
    gs.start = 1'b0;
    wait_cyc(1);

    // timer runs out on a LINE tile
    begin_game(72, 72);
    expect_at(1, F_TH, 4, "s2_tile_h");
    expect_at(1, F_TV, 4, "s2_tile_v");
    expect_at(3, F_TICK, 0, "s2_no_tick");
    expect_at(4, F_TICK, 1, "s2_tick1");
    expect_at(4, F_TL, 2, "s2_tl2");
    expect_at(5, F_TICK, 0, "s2_tick_one_cycle");
    expect_at(8, F_TICK, 1, "s2_tick2");
    expect_at(8, F_TL, 1, "s2_tl1");
    expect_at(11, F_STATE, ST_GAME, "s2_still_game");
    expect_at(12, F_STATE, ST_LOSE, "s2_timeout_lose");
    expect_at(12, F_TL, 0, "s2_tl0");
    expect_at(12, F_TICK, 1, "s2_tick3");
    expect_at(13, F_TICK, 0, "s2_no_tick_in_lose");
    expect_at(15, F_TL, 0, "s2_tl_frozen");
    wait_cyc(5);
    gs.start = 1'b1;
    expect_at(2, F_STATE, ST_GAME, "s2_start_ignored_in_game");
    wait_cyc(1);
    gs.start = 1'b0;
    wait_cyc(10);
    restart();

    // move onto TERMINAL mid-round
    begin_game(72, 72);
    wait_cyc(2);
    gs.charactor_h = 9'd88;
    expect_at(1, F_TH, 5, "s3_tile_h");
    expect_at(1, F_TV, 4, "s3_tile_v");
    expect_at(2, F_STATE, ST_GAME, "s3_game_before_win");
    expect_at(3, F_STATE, ST_WIN, "s3_win");
    expect_at(3, F_TL, 2, "s3_tl_at_win");
    expect_at(6, F_TL, 2, "s3_tl_frozen");
    expect_at(6, F_TICK, 0, "s3_no_tick_in_win");
    wait_cyc(7);
    expect_at(2, F_TH, 5, "s6_tile_h_hold");
    restart();

    // TERMINAL evaluation coincides with the final tick
    begin_game(72, 72);
    wait_cyc(9);
    gs.charactor_h = 9'd88;
    expect_at(2, F_STATE, ST_GAME, "s4_game_before_win");
    expect_at(3, F_STATE, ST_WIN, "s4_win_beats_timeout");
    expect_at(3, F_TL, 0, "s4_tl0");
    expect_at(3, F_TICK, 1, "s4_final_tick");
    wait_cyc(6);
    restart();

    // off-map x position
    begin_game(72, 72);
    wait_cyc(2);
    gs.charactor_h = 9'd330;
    expect_at(1, F_TH, 20, "s5_oob_tile_h");
    expect_at(2, F_STATE, ST_GAME, "s5_oob_game");
    expect_at(3, F_STATE, ST_LOSE, "s5_oob_lose");
    expect_at(3, F_TL, 2, "s5_oob_tl");
    wait_cyc(5);
    restart();

    // NONE tile under the character
    begin_game(8, 8);
    expect_at(1, F_TH, 0, "s5_none_tile_h");
    expect_at(2, F_STATE, ST_GAME, "s5_none_game");
    expect_at(3, F_STATE, ST_LOSE, "s5_none_lose");
    expect_at(3, F_TL, 3, "s5_none_tl");
    wait_cyc(5);
    restart();

    // reset mid-GAME
    begin_game(72, 72);
    expect_at(4, F_TL, 2, "s6_pre_tl");
    expect_at(5, F_STATE, ST_GAME, "s6_pre_game");
    wait_cyc(5);
    rst = 1'b1;
    expect_at(1, F_STATE, ST_INIT, "s6_rst_state");
    expect_at(1, F_TL, TIME_LIMIT, "s6_rst_tl");
    expect_at(1, F_TH, 0, "s6_rst_tile_h");
    expect_at(1, F_TICK, 0, "s6_rst_tick");
    expect_at(3, F_STATE, ST_WAIT, "s6_rst_wait");
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(7);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
